// File: rtl/csi_pkg.sv
// Shared definitions for the CSI capture controller: state encodings, register
// word indices and bit positions inside the CMD/STAT/IRQ registers.
package csi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAKE = 3'd1,
    ST_SYNC = 3'd2,
    ST_CAP  = 3'd3,
    ST_ERR  = 3'd4
  } cap_state_e;

  localparam logic [5:0] REG_CMD      = 6'h0;
  localparam logic [5:0] REG_STAT     = 6'h1;
  localparam logic [5:0] REG_SETTLE   = 6'h2;
  localparam logic [5:0] REG_FRM_NUM  = 6'h3;
  localparam logic [5:0] REG_FRM_CNT  = 6'h4;
  localparam logic [5:0] REG_TMO      = 6'h5;
  localparam logic [5:0] REG_IRQ_STAT = 6'h6;
  localparam logic [5:0] REG_IRQ_EN   = 6'h7;

  localparam int CMD_START_BIT = 0;
  localparam int CMD_STOP_BIT  = 1;

  localparam int STAT_OVF_BIT = 4;
  localparam int STAT_UDF_BIT = 5;
  localparam int STAT_TMO_BIT = 6;

  localparam int IRQ_DONE_BIT = 0;
  localparam int IRQ_ERR_BIT  = 1;

endpackage

// File: rtl/csi_cap_ctrl.sv
// CSI capture controller: register block plus the wake/sync/capture sequencer
// that gates SOF and pixel-valid into the capture path.
module csi_cap_ctrl
  import csi_pkg::*;
#(
  parameter int SETTLE_W = 16,
  parameter int TMO_W    = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ibus_cs,
  input  logic        ibus_wr,
  input  logic [7:0]  ibus_addr,
  input  logic [31:0] ibus_wrdata,
  output logic [31:0] ibus_rddata,
  input  logic        sof_in,
  input  logic        vin,
  input  logic        fifo_ovf,
  input  logic        fifo_udf,
  output logic        vrst_n,
  output logic        enb,
  output logic        cap_sof,
  output logic        cap_vld,
  output logic        irq
);

  cap_state_e          state_q, state_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d, tmo_next;
  logic [15:0]         frm_cnt_q, frm_cnt_d;
  logic                stop_pend_q, stop_pend_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_udf_q, err_udf_d;
  logic                err_tmo_q, err_tmo_d;
  logic                vrst_n_q, vrst_n_d;
  logic                enb_q, enb_d;
  logic                cap_sof_q, cap_sof_d;
  logic                cap_vld_q, cap_vld_d;

  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [15:0]         frm_num_q, frm_num_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [1:0]          irq_en_q, irq_en_d;
  logic [1:0]          irq_stat_q, irq_stat_d;
  logic [1:0]          irq_hw_set, irq_w1c;

  logic       wr_en, start_cmd, stop_cmd, fifo_err, tmo_hit, frames_done;
  logic [5:0] word;
  logic       unused_bus_bits;

  assign word            = ibus_addr[7:2];
  assign wr_en           = ibus_cs & ibus_wr;
  assign start_cmd       = wr_en && (word == REG_CMD) && ibus_wrdata[CMD_START_BIT];
  assign stop_cmd        = wr_en && (word == REG_CMD) && ibus_wrdata[CMD_STOP_BIT];
  assign fifo_err        = fifo_ovf | fifo_udf;
  assign tmo_next        = tmo_cnt_q + 1'b1;
  // Compare against the incremented count so the timeout fires exactly TMO
  // cycles after the last SOF (or after entering SYNC).
  assign tmo_hit         = (tmo_q != '0) && (tmo_next == tmo_q);
  assign frames_done     = (frm_num_q != 16'd0) && (frm_cnt_q == frm_num_q);
  assign unused_bus_bits = ^{ibus_addr[1:0], ibus_wrdata};

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    frm_cnt_d    = frm_cnt_q;
    stop_pend_d  = stop_pend_q;
    err_ovf_d    = err_ovf_q;
    err_udf_d    = err_udf_q;
    err_tmo_d    = err_tmo_q;
    cap_sof_d    = 1'b0;
    irq_hw_set   = '0;

    case (state_q)
      ST_IDLE: begin
        // STOP in the same write cancels START.
        if (start_cmd && !stop_cmd) begin
          state_d      = ST_WAKE;
          settle_cnt_d = '0;
          frm_cnt_d    = '0;
        end
      end
      ST_WAKE: begin
        if (stop_cmd) begin
          state_d = ST_IDLE;
        end else if (settle_cnt_q == settle_q) begin
          state_d   = ST_SYNC;
          tmo_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_SYNC: begin
        tmo_cnt_d = tmo_next;
        if (fifo_err) begin
          state_d                 = ST_ERR;
          err_ovf_d               = err_ovf_q | fifo_ovf;
          err_udf_d               = err_udf_q | fifo_udf;
          irq_hw_set[IRQ_ERR_BIT] = 1'b1;
        end else if (stop_cmd) begin
          state_d = ST_IDLE;
        end else if (sof_in) begin
          state_d   = ST_CAP;
          frm_cnt_d = 16'd1;
          cap_sof_d = 1'b1;
          tmo_cnt_d = '0;
        end else if (tmo_hit) begin
          state_d                 = ST_ERR;
          err_tmo_d               = 1'b1;
          irq_hw_set[IRQ_ERR_BIT] = 1'b1;
        end
      end
      ST_CAP: begin
        tmo_cnt_d = tmo_next;
        if (stop_cmd) stop_pend_d = 1'b1;
        if (fifo_err) begin
          state_d                 = ST_ERR;
          err_ovf_d               = err_ovf_q | fifo_ovf;
          err_udf_d               = err_udf_q | fifo_udf;
          irq_hw_set[IRQ_ERR_BIT] = 1'b1;
        end else if (sof_in) begin
          tmo_cnt_d = '0;
          if (stop_pend_q || stop_cmd || frames_done) begin
            state_d                  = ST_IDLE;
            irq_hw_set[IRQ_DONE_BIT] = 1'b1;
          end else begin
            frm_cnt_d = frm_cnt_q + 16'd1;
            cap_sof_d = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d                 = ST_ERR;
          err_tmo_d               = 1'b1;
          irq_hw_set[IRQ_ERR_BIT] = 1'b1;
        end
      end
      ST_ERR: begin
        if (stop_cmd) begin
          state_d   = ST_IDLE;
          err_ovf_d = 1'b0;
          err_udf_d = 1'b0;
          err_tmo_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != ST_CAP) stop_pend_d = 1'b0;
    if ((state_d != ST_SYNC) && (state_d != ST_CAP)) tmo_cnt_d = '0;

    // Outputs are decoded from the next state so they line up with state_q.
    vrst_n_d  = (state_d == ST_WAKE) || (state_d == ST_SYNC) || (state_d == ST_CAP);
    enb_d     = (state_d == ST_SYNC) || (state_d == ST_CAP);
    cap_vld_d = vin && (state_q == ST_CAP);
  end

  always_comb begin
    settle_d  = settle_q;
    frm_num_d = frm_num_q;
    tmo_d     = tmo_q;
    irq_en_d  = irq_en_q;
    irq_w1c   = '0;
    if (wr_en) begin
      case (word)
        REG_SETTLE:   settle_d  = ibus_wrdata[SETTLE_W-1:0];
        REG_FRM_NUM:  frm_num_d = ibus_wrdata[15:0];
        REG_TMO:      tmo_d     = ibus_wrdata[TMO_W-1:0];
        REG_IRQ_EN:   irq_en_d  = ibus_wrdata[1:0];
        REG_IRQ_STAT: irq_w1c   = ibus_wrdata[1:0];
        default: ;
      endcase
    end
  end

  // A hardware event in the same cycle as a W1C keeps the bit set.
  for (genvar gi = 0; gi < 2; gi++) begin : g_irq_bit
    assign irq_stat_d[gi] = irq_hw_set[gi] | (irq_stat_q[gi] & ~irq_w1c[gi]);
  end

  always_comb begin
    ibus_rddata = '0;
    if (ibus_cs) begin
      case (word)
        REG_STAT: begin
          ibus_rddata[2:0]          = state_q;
          ibus_rddata[STAT_OVF_BIT] = err_ovf_q;
          ibus_rddata[STAT_UDF_BIT] = err_udf_q;
          ibus_rddata[STAT_TMO_BIT] = err_tmo_q;
        end
        REG_SETTLE:   ibus_rddata[SETTLE_W-1:0] = settle_q;
        REG_FRM_NUM:  ibus_rddata[15:0]         = frm_num_q;
        REG_FRM_CNT:  ibus_rddata[15:0]         = frm_cnt_q;
        REG_TMO:      ibus_rddata[TMO_W-1:0]    = tmo_q;
        REG_IRQ_STAT: ibus_rddata[1:0]          = irq_stat_q;
        REG_IRQ_EN:   ibus_rddata[1:0]          = irq_en_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      frm_cnt_q    <= '0;
      stop_pend_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_udf_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
      vrst_n_q     <= 1'b0;
      enb_q        <= 1'b0;
      cap_sof_q    <= 1'b0;
      cap_vld_q    <= 1'b0;
      settle_q     <= '0;
      frm_num_q    <= '0;
      tmo_q        <= '0;
      irq_en_q     <= '0;
      irq_stat_q   <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
      stop_pend_q  <= stop_pend_d;
      err_ovf_q    <= err_ovf_d;
      err_udf_q    <= err_udf_d;
      err_tmo_q    <= err_tmo_d;
      vrst_n_q     <= vrst_n_d;
      enb_q        <= enb_d;
      cap_sof_q    <= cap_sof_d;
      cap_vld_q    <= cap_vld_d;
      settle_q     <= settle_d;
      frm_num_q    <= frm_num_d;
      tmo_q        <= tmo_d;
      irq_en_q     <= irq_en_d;
      irq_stat_q   <= irq_stat_d;
    end
  end

  assign vrst_n  = vrst_n_q;
  assign enb     = enb_q;
  assign cap_sof = cap_sof_q;
  assign cap_vld = cap_vld_q;
  assign irq     = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_csi_cap_ctrl.sv
// Self-checking bench for csi_cap_ctrl: register table, directed capture
// sequences and randomized frame streams checked by an event-counting model.
module tb_csi_cap_ctrl;
  import csi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ibus_cs = 1'b0;
  logic        ibus_wr = 1'b0;
  logic [7:0]  ibus_addr = '0;
  logic [31:0] ibus_wrdata = '0;
  logic [31:0] ibus_rddata;
  logic        sof_in = 1'b0;
  logic        vin = 1'b0;
  logic        fifo_ovf = 1'b0;
  logic        fifo_udf = 1'b0;
  logic        vrst_n, enb, cap_sof, cap_vld, irq;

  int checks = 0;
  int failures = 0;

  csi_cap_ctrl #(.SETTLE_W(16), .TMO_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_cs(ibus_cs), .ibus_wr(ibus_wr), .ibus_addr(ibus_addr),
    .ibus_wrdata(ibus_wrdata), .ibus_rddata(ibus_rddata),
    .sof_in(sof_in), .vin(vin), .fifo_ovf(fifo_ovf), .fifo_udf(fifo_udf),
    .vrst_n(vrst_n), .enb(enb), .cap_sof(cap_sof), .cap_vld(cap_vld), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  wr_word;
    logic [31:0] wdata;
    logic [5:0]  rd_word;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] w, input logic [31:0] d);
    ibus_cs = 1'b1; ibus_wr = 1'b1; ibus_addr = {w, 2'b00}; ibus_wrdata = d;
    tick();
    ibus_cs = 1'b0; ibus_wr = 1'b0; ibus_wrdata = '0;
  endtask

  task automatic bus_read(input logic [5:0] w, output logic [31:0] d);
    ibus_cs = 1'b1; ibus_wr = 1'b0; ibus_addr = {w, 2'b00};
    #1;
    d = ibus_rddata;
    ibus_cs = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [5:0] w, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(w, d);
    check(name, d, exp);
  endtask

  // Waits for enb to rise; returns the number of cycles it took.
  task automatic wait_enb(input string name, output int n);
    n = 0;
    while (!enb && n < 64) begin
      tick();
      n++;
    end
    if (!enb) check({name, "_enb_timeout"}, 32'(enb), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, s, fn, gap, exp_vld, got_vld, got_sof;
    logic [31:0] rd;

    vecs[0]  = '{"rw_settle",     REG_SETTLE,   32'hABCD1234, REG_SETTLE,   32'h0000_1234};
    vecs[1]  = '{"rw_frm_num",    REG_FRM_NUM,  32'hFFFF0007, REG_FRM_NUM,  32'h0000_0007};
    vecs[2]  = '{"rw_tmo",        REG_TMO,      32'hFF123456, REG_TMO,      32'h0012_3456};
    vecs[3]  = '{"rw_irq_en",     REG_IRQ_EN,   32'hFFFFFFFF, REG_IRQ_EN,   32'h0000_0003};
    vecs[4]  = '{"ro_stat",       REG_STAT,     32'hFFFFFFFF, REG_STAT,     32'h0};
    vecs[5]  = '{"ro_frm_cnt",    REG_FRM_CNT,  32'h00001234, REG_FRM_CNT,  32'h0};
    vecs[6]  = '{"wo_cmd",        REG_CMD,      32'h00000000, REG_CMD,      32'h0};
    vecs[7]  = '{"unmapped",      6'h3F,        32'h0000FFFF, 6'h3F,        32'h0};
    vecs[8]  = '{"w1c_empty",     REG_IRQ_STAT, 32'hFFFFFFFF, REG_IRQ_STAT, 32'h0};
    vecs[9]  = '{"rw_irq_en2",    REG_IRQ_EN,   32'h00000002, REG_IRQ_EN,   32'h0000_0002};
    vecs[10] = '{"stop_in_idle",  REG_CMD,      32'h00000002, REG_STAT,     32'h0};
    vecs[11] = '{"start_and_stop",REG_CMD,      32'h00000003, REG_STAT,     32'h0};

    // Reset state
    tick(); tick();
    check("rst_outputs", {27'b0, vrst_n, enb, cap_sof, cap_vld, irq}, 32'h0);
    rst_n = 1'b1;
    tick();
    for (int w = 0; w < 8; w++) begin
      bus_read(6'(w), rd);
      check($sformatf("rst_reg%0d", w), rd, 32'h0);
    end

    // Register table
    for (int i = 0; i < 12; i++) begin
      bus_write(vecs[i].wr_word, vecs[i].wdata);
      bus_read(vecs[i].rd_word, rd);
      check(vecs[i].name, rd, vecs[i].exp);
    end
    check("start_stop_vrst", 32'(vrst_n), 32'd0);
    ibus_addr = {REG_SETTLE, 2'b00}; ibus_cs = 1'b0; #1;
    check("rdata_no_cs", ibus_rddata, 32'h0);

    // Basic capture: SETTLE=5, two frames, third SOF ends it
    bus_write(REG_SETTLE, 5); bus_write(REG_FRM_NUM, 2); bus_write(REG_TMO, 0);
    bus_write(REG_IRQ_EN, 1); bus_write(REG_IRQ_STAT, 3);
    bus_write(REG_CMD, 1);
    check("basic_vrst_rise", {30'b0, vrst_n, enb}, 32'b10);
    wait_enb("basic", n);
    check("basic_settle_cycles", n, 6);
    got_sof = 0;
    for (int f = 0; f < 3; f++) begin
      repeat (3) begin tick(); got_sof += int'(cap_sof); end
      sof_in = 1'b1; tick(); sof_in = 1'b0; got_sof += int'(cap_sof);
    end
    repeat (2) begin tick(); got_sof += int'(cap_sof); end
    check("basic_cap_sof_count", got_sof, 2);
    chk_reg("basic_stat_idle", REG_STAT, 0);
    chk_reg("basic_frm_cnt", REG_FRM_CNT, 2);
    chk_reg("basic_done", REG_IRQ_STAT, 1);
    check("basic_irq_vrst", {30'b0, irq, vrst_n}, 32'b10);

    // Randomized frame streams against a counting model
    for (int it = 0; it < 6; it++) begin
      s  = int'($urandom_range(0, 12));
      fn = int'($urandom_range(1, 4));
      bus_write(REG_SETTLE, 32'(s)); bus_write(REG_FRM_NUM, 32'(fn));
      bus_write(REG_IRQ_STAT, 3);
      bus_write(REG_CMD, 1);
      wait_enb("rnd", n);
      check($sformatf("rnd%0d_settle", it), n, s + 1);
      exp_vld = 0; got_vld = 0; got_sof = 0;
      for (int f = 0; f <= fn; f++) begin
        gap = int'($urandom_range(2, 8));
        for (int g = 0; g < gap; g++) begin
          vin = 1'($urandom_range(0, 1));
          if (f > 0) exp_vld += int'(vin);
          tick();
          got_vld += int'(cap_vld); got_sof += int'(cap_sof);
        end
        vin = 1'($urandom_range(0, 1));
        if (f > 0) exp_vld += int'(vin);
        sof_in = 1'b1; tick(); sof_in = 1'b0;
        got_vld += int'(cap_vld); got_sof += int'(cap_sof);
      end
      vin = 1'b0;
      repeat (3) begin tick(); got_vld += int'(cap_vld); got_sof += int'(cap_sof); end
      check($sformatf("rnd%0d_sof_count", it), got_sof, fn);
      check($sformatf("rnd%0d_vld_count", it), got_vld, exp_vld);
      chk_reg($sformatf("rnd%0d_frm_cnt", it), REG_FRM_CNT, 32'(fn));
      chk_reg($sformatf("rnd%0d_stat", it), REG_STAT, 0);
      check($sformatf("rnd%0d_irq", it), 32'(irq), 32'd1);
    end

    // Continuous capture, STOP mid-frame waits for the next SOF
    bus_write(REG_SETTLE, 0); bus_write(REG_FRM_NUM, 0); bus_write(REG_IRQ_STAT, 3);
    bus_write(REG_CMD, 1);
    wait_enb("stop", n);
    vin = 1'b1;
    sof_in = 1'b1; tick(); sof_in = 1'b0;
    check("stop_first_sof", 32'(cap_sof), 32'd1);
    repeat (3) tick();
    bus_write(REG_CMD, 2);
    repeat (4) tick();
    check("stop_vld_continues", 32'(cap_vld), 32'd1);
    chk_reg("stop_still_cap", REG_STAT, 3);
    sof_in = 1'b1;
    bus_write(REG_IRQ_STAT, 1);
    sof_in = 1'b0;
    check("stop_no_sof_vld", {30'b0, cap_sof, cap_vld}, 32'b01);
    chk_reg("stop_idle", REG_STAT, 0);
    chk_reg("stop_done_set_wins", REG_IRQ_STAT, 1);
    tick();
    check("stop_vld_off", 32'(cap_vld), 32'd0);
    chk_reg("stop_frm_cnt", REG_FRM_CNT, 1);
    vin = 1'b0;

    // SOF timeout in SYNC
    bus_write(REG_IRQ_STAT, 3); bus_write(REG_IRQ_EN, 2); bus_write(REG_TMO, 100);
    bus_write(REG_CMD, 1);
    wait_enb("tmo", n);
    n = 0;
    while (vrst_n && n < 300) begin tick(); n++; end
    check("tmo_cycles", n, 100);
    chk_reg("tmo_stat", REG_STAT, 32'h44);
    chk_reg("tmo_irq_stat", REG_IRQ_STAT, 2);
    check("tmo_irq_enb", {30'b0, irq, enb}, 32'b10);
    bus_write(REG_CMD, 2);
    chk_reg("tmo_stop_clears", REG_STAT, 0);
    bus_write(REG_IRQ_STAT, 2);
    check("tmo_irq_cleared", 32'(irq), 32'd0);

    // FIFO overflow in CAP, underflow in SYNC
    bus_write(REG_TMO, 0);
    bus_write(REG_CMD, 1);
    wait_enb("ovf", n);
    sof_in = 1'b1; tick(); sof_in = 1'b0;
    tick();
    fifo_ovf = 1'b1; tick(); fifo_ovf = 1'b0;
    chk_reg("ovf_stat", REG_STAT, 32'h14);
    check("ovf_outputs", {30'b0, vrst_n, enb}, 32'b00);
    chk_reg("ovf_irq_stat", REG_IRQ_STAT, 2);
    bus_write(REG_CMD, 2);
    chk_reg("ovf_stop_clears", REG_STAT, 0);
    bus_write(REG_CMD, 1);
    wait_enb("udf", n);
    fifo_udf = 1'b1; tick(); fifo_udf = 1'b0;
    chk_reg("udf_stat", REG_STAT, 32'h24);
    bus_write(REG_CMD, 2);
    chk_reg("udf_stop_clears", REG_STAT, 0);

    // Reset asserted while capturing
    bus_write(REG_SETTLE, 3);
    bus_write(REG_CMD, 1);
    wait_enb("rstcap", n);
    vin = 1'b1;
    sof_in = 1'b1; tick(); sof_in = 1'b0;
    tick();
    chk_reg("rstcap_in_cap", REG_STAT, 3);
    check("rstcap_pre_irq_vld", {30'b0, irq, cap_vld}, 32'b11);
    rst_n = 1'b0; sof_in = 1'b1;
    tick();
    check("rstcap_outputs", {27'b0, vrst_n, enb, cap_sof, cap_vld, irq}, 32'h0);
    chk_reg("rstcap_stat", REG_STAT, 0);
    chk_reg("rstcap_settle", REG_SETTLE, 0);
    rst_n = 1'b1; sof_in = 1'b0; vin = 1'b0;
    tick();
    chk_reg("rstcap_frm_cnt", REG_FRM_CNT, 0);
    chk_reg("rstcap_irq_en", REG_IRQ_EN, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csi_cap_ctrl.md
CSI_CAP_CTRL -- requirements
Module: csi_cap_ctrl

Interface
REQ-001 Params: SETTLE_W, default 16, width of the settle-delay counter; TMO_W, default 24, width of the SOF-timeout counter.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 ibus_cs / ibus_wr  in  1/1  bus select / write strobe; a write takes effect when both are high.
REQ-005 ibus_addr  in  8  byte address; word index is ibus_addr[7:2].
REQ-006 ibus_wrdata / ibus_rddata  in/out  32/32  write data / combinational read data; read data is 0 when ibus_cs=0.
REQ-007 sof_in, vin  in  1/1  delay-matched start-of-frame pulse and pixel valid.
REQ-008 fifo_ovf, fifo_udf  in  1/1  delay-FIFO error flags, level-sensitive.
REQ-009 vrst_n, enb  out  1/1  CSI receiver reset release and delay-matcher enable.
REQ-010 cap_sof, cap_vld  out  1/1  gated sof_in and gated vin for the capture path.
REQ-011 irq  out  1  level interrupt: OR of the enabled IRQ status bits.

Function
REQ-012 Register map (word index):
- 0x0 CMD, write-only: bit0 START, bit1 STOP, single-cycle pulses.
- 0x1 STAT, read-only: [2:0] state, bit4 ERR_OVF, bit5 ERR_UDF, bit6 ERR_TMO.
- 0x2 SETTLE, R/W, [15:0].
- 0x3 FRM_NUM, R/W, [15:0]; 0 = continuous capture.
- 0x4 FRM_CNT, read-only, [15:0].
- 0x5 TMO, R/W, [23:0]; 0 = timeout disabled.
- 0x6 IRQ_STAT: bit0 DONE, bit1 ERR; write-1-to-clear.
- 0x7 IRQ_EN, R/W, [1:0].
REQ-013 States and encodings: IDLE=0, WAKE=1, SYNC=2, CAP=3, ERR=4.
REQ-014 Output decode (all outputs registered from the state):
- IDLE: vrst_n=0, enb=0.
- WAKE: vrst_n=1, enb=0.
- SYNC, CAP: vrst_n=1, enb=1.
- ERR: vrst_n=0, enb=0.
REQ-015 IDLE→WAKE on START; the settle counter loads 0.
REQ-016 WAKE→SYNC when the settle counter equals SETTLE; SETTLE=0 passes through WAKE in one cycle.
REQ-017 SYNC→CAP on sof_in: FRM_CNT←1, cap_sof=1 on the next cycle.
REQ-018 In CAP, on sof_in:
- If STOP is pending, or FRM_NUM≠0 and FRM_CNT==FRM_NUM: go to IDLE, no cap_sof, set IRQ DONE.
- Otherwise: FRM_CNT increments (16-bit, wraps 0xFFFF→0), cap_sof=1 on the next cycle.
REQ-019 cap_vld = vin registered, gated by state==CAP; latency 1 cycle.
REQ-020 STOP handling:
- In WAKE or SYNC: go to IDLE immediately.
- In CAP: set stop_pend; stop occurs at the next frame boundary (REQ-018).
- In ERR: go to IDLE and clear the ERR_* bits.
- In IDLE: no effect.
REQ-021 START is ignored outside IDLE; START and STOP in the same write means STOP wins.
REQ-022 fifo_ovf or fifo_udf high in SYNC or CAP: go to ERR, set the matching sticky ERR_* bit, set IRQ ERR.
REQ-023 SOF timeout:
- Counter runs in SYNC and CAP and clears on each sof_in.
- When TMO≠0 and counter==TMO: go to ERR, set ERR_TMO and IRQ ERR.
REQ-024 Simultaneous hardware set and software W1C on an IRQ_STAT bit: set wins.
REQ-025 FRM_CNT clears on START and holds its value in IDLE and ERR.

Reset
REQ-026 rst_n=0 forces the following; all other state also returns to IDLE:
- state=IDLE, all registers and counters 0, stop_pend=0.
- vrst_n=0, enb=0, cap_sof=0, cap_vld=0, irq=0.
REQ-027 Reset asserted mid-capture takes effect on the next clk edge; no frame-boundary wait.

Structure
REQ-028 Shared package csi_pkg holds: state encodings, register word indices, STAT/IRQ bit positions.
REQ-029 The block is a single module with no sub-modules.

Verification
REQ-030 SETTLE=5, FRM_NUM=2, START, 3 sof_in → vrst_n rises 1 cycle after START; enb rises 6 cycles later; 2 cap_sof pulses; third sof → IDLE, DONE=1, FRM_CNT=2.
REQ-031 FRM_NUM=0, STOP mid-frame in CAP → cap_vld continues to the next sof_in, then IDLE, no cap_sof at that sof.
REQ-032 TMO=100, no sof_in in SYNC → ERR at cycle 100, ERR_TMO=1, vrst_n=0, irq=1 with IRQ_EN=2.
REQ-033 fifo_ovf pulse in CAP → ERR, ERR_OVF=1; STOP → IDLE, STAT err bits = 0.
REQ-034 START+STOP written together in IDLE → stays IDLE; rst_n=0 in CAP → all outputs 0 on the next cycle.
